sensor_req_scheduler: RTL
=========================

Name: sensor_req_scheduler

Overview:
- Sequences each request from the UART receiver to the sensor modules.
- Assembles a 2-byte request frame (command, address) from UART RX and issues a one-cycle one-hot dispatch strobe to the addressed sensor module.
- Waits for that module's 16-bit response, with a timeout, then serialises the response as 2 bytes onto the shared UART TX.
- Owns UART TX exclusively and handles one request at a time.

Parameters:
- N_MODULES, 32, number of sensor modules present; addresses >= N_MODULES are invalid.
- TIMEOUT_CYCLES, 1000000, clock cycles allowed for the second request byte and for a module response.
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_done  in  1  one-cycle pulse: UART RX byte available on rx_data.
- rx_data  in  8  received byte, valid while rx_done=1.
- cmd_out  out  8  latched command byte, broadcast to all modules.
- addr_out  out  5  latched target address.
- dispatch  out  32  one-hot, one-cycle strobe to the addressed module; bits >= N_MODULES are always 0.
- resp_valid  in  1  one-cycle pulse from the selected module (externally muxed by addr_out).
- resp_data  in  16  module response; [15:8] status code, [7:0] value.
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the byte is sent.
- tx_start  out  1  one-cycle pulse to start a UART TX byte.
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE; counter is cleared.
  - cmd_out=0, addr_out=0, dispatch=0, tx_start=0, tx_data=0, busy=0.
  - Applies from any state, including mid-transmission; the TX byte in flight is abandoned with no further tx_start.
- States:
  - IDLE: on rx_done, latch rx_data into cmd_out and go to WAIT_ADDR.
  - WAIT_ADDR: counter increments every cycle.
    - rx_done with rx_data[7:5]=0 and rx_data[4:0] < N_MODULES: latch addr_out and go to DISPATCH.
    - rx_done with an invalid byte: load the response register with {8'hFE, rx_data} and go to SEND_HI.
    - Counter reaches TIMEOUT_CYCLES with no byte: return to IDLE silently; no TX.
  - DISPATCH (exactly 1 cycle): dispatch[addr_out]=1; go to WAIT_RESP with the counter cleared.
    - Latency from second rx_done to dispatch is exactly 2 cycles.
  - WAIT_RESP:
    - On resp_valid, capture resp_data and go to SEND_HI.
    - If the counter reaches TIMEOUT_CYCLES first, load {8'hFF, 3'b000, addr_out} and go to SEND_HI.
    - resp_valid in the same cycle the counter reaches TIMEOUT_CYCLES: the response wins.
  - SEND_HI: wait until tx_busy=0, then pulse tx_start with tx_data=resp[15:8]; go to WAIT_HI.
  - WAIT_HI: wait for tx_busy to rise and then fall; go to SEND_LO.
  - SEND_LO / WAIT_LO: same handshake with resp[7:0]; return to IDLE after tx_busy falls.
- Ignored inputs:
  - rx_done outside IDLE/WAIT_ADDR is dropped; no queueing.
  - resp_valid outside WAIT_RESP is ignored.
- Hold rules:
  - tx_data holds its value between bytes.
  - cmd_out and addr_out hold until the next frame overwrites them.
- Counter: saturates (no wrap) and is cleared on every state entry.

Test Plan:
- Normal path: rx bytes 8'h03 then 8'h05; module asserts resp_valid with 16'h0A1B 10 cycles after dispatch; TX model holds tx_busy for 20 cycles per byte.
  - dispatch = 32'h0000_0020 for exactly 1 cycle, 2 cycles after the second rx_done.
  - TX emits 8'h0A then 8'h1B; busy returns to 0 after the second tx_busy fall.
- Invalid address, N_MODULES=9: bytes 8'h01 then 8'h0C.
  - No dispatch; TX emits 8'hFE, 8'h0C.
- Invalid address, upper bits set: second byte 8'h25.
  - No dispatch; TX emits 8'hFE, 8'h25.
- Response timeout, TIMEOUT_CYCLES=100: valid frame to address 2, no resp_valid.
  - TX emits 8'hFF, 8'h02 starting in cycle 101 after dispatch.
- Inter-byte timeout: single byte 8'h07, then silence for TIMEOUT_CYCLES.
  - Returns to IDLE; no dispatch; no tx_start.
  - A following frame 8'h01, 8'h00 is handled normally (dispatch bit 0).
- Reset and dropped inputs:
  - reset_n=0 asserted in WAIT_HI: next cycle all outputs are 0 and state is IDLE; no second byte is sent.
  - rx_done pulsed during WAIT_RESP: ignored; the response for the original address is still transmitted.

Source files
------------

// File: rtl/sensor_req_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_req_scheduler
//
// Handles one sensor request at a time. A 2-byte frame (command, address)
// arrives from the UART receiver. A valid address produces a one-cycle one-hot
// dispatch strobe to that sensor module. The module's 16-bit response, or a
// locally generated error code, is then sent back as two bytes on the UART
// transmitter. This block is the only user of the transmitter.
//
// Error responses:
//   {8'hFE, addr_byte}         address byte out of range
//   {8'hFF, 3'b000, addr_out}  no module response within TIMEOUT_CYCLES
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   rx_done     one-cycle pulse, rx_data holds a received byte
//   rx_data     received byte
//   cmd_out     latched command byte, broadcast to all modules
//   addr_out    latched target address
//   dispatch    one-hot, one-cycle strobe to the addressed module
//   resp_valid  one-cycle response pulse from the selected module
//   resp_data   module response, [15:8] status, [7:0] value
//   tx_busy     UART TX busy, rises the cycle after tx_start
//   tx_start    one-cycle pulse that starts a TX byte
//   tx_data     TX byte, held until the next byte is started
//   busy        high whenever a request is in progress
// -----------------------------------------------------------------------------
module sensor_req_scheduler #(
  parameter int N_MODULES      = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20     // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [7:0]  cmd_out,
  output logic [4:0]  addr_out,
  output logic [31:0] dispatch,
  input  logic        resp_valid,
  input  logic [15:0] resp_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_DISPATCH,
    S_WAIT_RESP,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO
  } state_t;

  // The timeout fires on the edge where the counter would reach
  // TIMEOUT_CYCLES, so a wait state lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] L_CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX    = '1;
  localparam logic [63:0]      L_MASK64     = (64'd1 << N_MODULES) - 64'd1;
  localparam logic [31:0]      L_VALID_MASK = L_MASK64[31:0];

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_cmd;
  logic [4:0]        r_addr;
  logic [15:0]       r_resp;
  logic [31:0]       r_dispatch;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_seen_busy;   // tx_busy has risen for the byte in flight

  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [7:0]        w_cmd_next;
  logic [4:0]        w_addr_next;
  logic [15:0]       w_resp_next;
  logic [31:0]       w_dispatch_next;
  logic              w_tx_start_next;
  logic [7:0]        w_tx_data_next;
  logic              w_seen_busy_next;
  logic              w_timeout;
  logic              w_addr_ok;

  assign w_timeout = (r_cnt == L_CNT_LAST);
  assign w_addr_ok = (rx_data[7:5] == 3'b000) && (int'(rx_data[4:0]) < N_MODULES);

  // Cleared on every state change, otherwise counts up and sticks at the top.
  assign w_cnt_next = (w_state_next != r_state) ? '0 :
                      (r_cnt == L_CNT_MAX)      ? r_cnt :
                                                  r_cnt + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    w_state_next     = r_state;
    w_cmd_next       = r_cmd;
    w_addr_next      = r_addr;
    w_resp_next      = r_resp;
    w_dispatch_next  = '0;
    w_tx_start_next  = 1'b0;
    w_tx_data_next   = r_tx_data;
    w_seen_busy_next = r_seen_busy;

    unique case (r_state)
      S_IDLE: begin
        if (rx_done) begin
          w_cmd_next   = rx_data;
          w_state_next = S_WAIT_ADDR;
        end
      end

      S_WAIT_ADDR: begin
        if (rx_done) begin
          if (w_addr_ok) begin
            w_addr_next  = rx_data[4:0];
            w_state_next = S_DISPATCH;
          end else begin
            w_resp_next  = {8'hFE, rx_data};
            w_state_next = S_SEND_HI;
          end
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end

      // dispatch is registered, so the strobe is visible during the cycle
      // after this state: two cycles after the address byte's rx_done.
      S_DISPATCH: begin
        w_dispatch_next = (32'd1 << r_addr) & L_VALID_MASK;
        w_state_next    = S_WAIT_RESP;
      end

      // A response in the timeout cycle itself still wins.
      S_WAIT_RESP: begin
        if (resp_valid) begin
          w_resp_next  = resp_data;
          w_state_next = S_SEND_HI;
        end else if (w_timeout) begin
          w_resp_next  = {8'hFF, 3'b000, r_addr};
          w_state_next = S_SEND_HI;
        end
      end

      S_SEND_HI: begin
        if (!tx_busy) begin
          w_tx_start_next  = 1'b1;
          w_tx_data_next   = r_resp[15:8];
          w_seen_busy_next = 1'b0;
          w_state_next     = S_WAIT_HI;
        end
      end

      // tx_busy is still low in the first cycle after tx_start, so wait for
      // it to rise before treating a low level as "byte sent".
      S_WAIT_HI: begin
        if (tx_busy) begin
          w_seen_busy_next = 1'b1;
        end else if (r_seen_busy) begin
          w_state_next = S_SEND_LO;
        end
      end

      S_SEND_LO: begin
        if (!tx_busy) begin
          w_tx_start_next  = 1'b1;
          w_tx_data_next   = r_resp[7:0];
          w_seen_busy_next = 1'b0;
          w_state_next     = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (tx_busy) begin
          w_seen_busy_next = 1'b1;
        end else if (r_seen_busy) begin
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_resp      <= '0;
      r_dispatch  <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cmd       <= w_cmd_next;
      r_addr      <= w_addr_next;
      r_resp      <= w_resp_next;
      r_dispatch  <= w_dispatch_next;
      r_tx_start  <= w_tx_start_next;
      r_tx_data   <= w_tx_data_next;
      r_seen_busy <= w_seen_busy_next;
    end
  end

  assign cmd_out  = r_cmd;
  assign addr_out = r_addr;
  assign dispatch = r_dispatch;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != S_IDLE);

endmodule
